// File: rtl/md5_stream_core_if.sv
// rtl/md5_stream_core_if.sv - block-in / digest-out stream bundle for md5_stream_core
interface md5_stream_core_if;
   logic         in_valid;
   logic         in_ready;
   logic         in_first;
   logic         in_last;
   logic [511:0] in_data;
   logic         hash_valid;
   logic         hash_ready;
   logic [127:0] hash;

   modport master (
      output in_valid, in_first, in_last, in_data, hash_ready,
      input  in_ready, hash_valid, hash
   );

   modport slave (
      input  in_valid, in_first, in_last, in_data, hash_ready,
      output in_ready, hash_valid, hash
   );
endinterface

// File: rtl/md5_stream_core.sv
// rtl/md5_stream_core.sv - MD5 compression engine, UNROLL steps per clock, multi-block chaining.
// Optional MD5_CUSTOM_IV_EN adds iv_in to seed the chaining state on an in_first accept.
module md5_stream_core #(
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             rst,
   md5_stream_core_if.slave s,
   output logic             busy
`ifdef MD5_CUSTOM_IV_EN
   ,
   input  logic [127:0]     iv_in
`endif
);

   generate
      if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
         $error("md5_stream_core: UNROLL must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SUM, ST_OUT} state_t;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;
   localparam logic [5:0]  STEP_INC  = 6'(UNROLL);
   localparam logic [5:0]  STEP_LAST = 6'(64 - UNROLL);

   localparam logic [31:0] K_TAB [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
      return (x << n) | (x >> (6'd32 - {1'b0, n}));
   endfunction

   function automatic logic [4:0] rot_amt(input logic [5:0] i);
      case ({i[5:4], i[1:0]})
         4'h0: return 5'd7;   4'h1: return 5'd12;  4'h2: return 5'd17;  4'h3: return 5'd22;
         4'h4: return 5'd5;   4'h5: return 5'd9;   4'h6: return 5'd14;  4'h7: return 5'd20;
         4'h8: return 5'd4;   4'h9: return 5'd11;  4'ha: return 5'd16;  4'hb: return 5'd23;
         4'hc: return 5'd6;   4'hd: return 5'd10;  4'he: return 5'd15;  default: return 5'd21;
      endcase
   endfunction

   // Message word schedule for each of the four rounds, modulo 16.
   function automatic logic [3:0] g_index(input logic [5:0] i);
      case (i[5:4])
         2'd0:    return i[3:0];
         2'd1:    return i[3:0] * 4'd5 + 4'd1;
         2'd2:    return i[3:0] * 4'd3 + 4'd5;
         default: return i[3:0] * 4'd7;
      endcase
   endfunction

   function automatic logic [31:0] f_func(input logic [1:0] r, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
      case (r)
         2'd0:    return (b & c) | (~b & d);
         2'd1:    return (d & b) | (~d & c);
         2'd2:    return b ^ c ^ d;
         default: return c ^ (b | ~d);
      endcase
   endfunction

   state_t       state, state_n;
   logic         accept;
   logic [5:0]   step_q;
   logic [511:0] blk_q;
   logic         last_q;
   logic [31:0]  wa_q, wb_q, wc_q, wd_q;
   logic [31:0]  ha_q, hb_q, hc_q, hd_q;
   logic [127:0] hash_q;
   logic [31:0]  na, nb, nc, nd;
   logic [31:0]  sum_a, sum_b, sum_c, sum_d;
   logic [31:0]  iv_a, iv_b, iv_c, iv_d;
   logic [31:0]  m_word [16];

`ifdef MD5_CUSTOM_IV_EN
   assign iv_a = bswap32(iv_in[127:96]);
   assign iv_b = bswap32(iv_in[95:64]);
   assign iv_c = bswap32(iv_in[63:32]);
   assign iv_d = bswap32(iv_in[31:0]);
`else
   assign iv_a = IV_A;
   assign iv_b = IV_B;
   assign iv_c = IV_C;
   assign iv_d = IV_D;
`endif

   assign s.in_ready   = (state == ST_IDLE) & ~rst;
   assign s.hash_valid = (state == ST_OUT);
   assign s.hash       = hash_q;
   assign busy         = (state == ST_RUN) | (state == ST_SUM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         ST_IDLE: if (s.in_valid) begin
            accept  = 1'b1;
            state_n = ST_RUN;
         end
         ST_RUN:  if (step_q == STEP_LAST) state_n = ST_SUM;
         ST_SUM:  state_n = last_q ? ST_OUT : ST_IDLE;
         ST_OUT:  if (s.hash_ready) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Byte 0 of the block sits in the top byte; MD5 words are little-endian.
   always_comb begin
      for (int j = 0; j < 16; j++) m_word[j] = bswap32(blk_q[511 - 32*j -: 32]);
   end

   always_comb begin : step_chain
      logic [31:0] ta, tb, tc, td, tmp;
      logic [5:0]  si;
      ta  = wa_q;
      tb  = wb_q;
      tc  = wc_q;
      td  = wd_q;
      tmp = '0;
      si  = '0;
      for (int u = 0; u < UNROLL; u++) begin
         si  = step_q + 6'(u);
         tmp = ta + f_func(si[5:4], tb, tc, td) + K_TAB[si] + m_word[g_index(si)];
         ta  = td;
         td  = tc;
         tc  = tb;
         tb  = tc + rotl32(tmp, rot_amt(si));
      end
      na = ta;
      nb = tb;
      nc = tc;
      nd = td;
   end

   assign sum_a = ha_q + wa_q;
   assign sum_b = hb_q + wb_q;
   assign sum_c = hc_q + wc_q;
   assign sum_d = hd_q + wd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= '0;
         blk_q  <= '0;
         last_q <= 1'b0;
         wa_q   <= '0;
         wb_q   <= '0;
         wc_q   <= '0;
         wd_q   <= '0;
         ha_q   <= IV_A;
         hb_q   <= IV_B;
         hc_q   <= IV_C;
         hd_q   <= IV_D;
         hash_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               blk_q  <= s.in_data;
               last_q <= s.in_last;
               step_q <= '0;
               if (s.in_first) begin
                  {wa_q, wb_q, wc_q, wd_q} <= {iv_a, iv_b, iv_c, iv_d};
                  {ha_q, hb_q, hc_q, hd_q} <= {iv_a, iv_b, iv_c, iv_d};
               end else begin
                  {wa_q, wb_q, wc_q, wd_q} <= {ha_q, hb_q, hc_q, hd_q};
               end
            end
            ST_RUN: begin
               step_q <= step_q + STEP_INC;
               {wa_q, wb_q, wc_q, wd_q} <= {na, nb, nc, nd};
            end
            ST_SUM: begin
               {ha_q, hb_q, hc_q, hd_q} <= {sum_a, sum_b, sum_c, sum_d};
               if (last_q)
                  hash_q <= {bswap32(sum_a), bswap32(sum_b), bswap32(sum_c), bswap32(sum_d)};
            end
            ST_OUT: if (s.hash_ready) begin
               // Next message chains from the standard IV even without in_first.
               {ha_q, hb_q, hc_q, hd_q} <= {IV_A, IV_B, IV_C, IV_D};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_md5_stream_core.sv
// tb/tb_md5_stream_core.sv - scoreboard bench for md5_stream_core, UNROLL=1 and UNROLL=4 instances
`timescale 1ns/1ps
module tb_md5_stream_core;

   localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
   localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 8'h18, 56'h0};
   localparam logic [511:0] BLK_D1    = {{6{80'h31323334353637383930}}, 32'h31323334};
   localparam logic [511:0] BLK_D2    = {128'h35363738393031323334353637383930, 8'h80, 312'h0, 16'h8002, 48'h0};
   localparam logic [127:0] H_EMPTY   = 128'hd41d8cd98f00b204e9800998ecf8427e;
   localparam logic [127:0] H_ABC     = 128'h900150983cd24fb0d6963f7d28e17f72;
   localparam logic [127:0] H_DIG     = 128'h57edf4a22be3c955ac49da2e2107b67a;

   typedef struct {
      logic [127:0] hash;
      int           acc;
      bit           chk;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         busy1, busy4;
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   exp_t         q1[$];
   exp_t         q4[$];
   exp_t         e1, e4;
   bit           seen1 = 0, seen4 = 0;
   logic [127:0] cap_h = '0;
   bit           cap_done = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   md5_stream_core_if if1 ();
   md5_stream_core_if if4 ();

`ifdef MD5_CUSTOM_IV_EN
   localparam logic [127:0] IV_STD = 128'h0123456789abcdeffedcba9876543210;
   logic [127:0] iv_in;
`endif

   md5_stream_core #(.UNROLL(1)) dut1 (
      .clk(clk), .rst(rst), .s(if1), .busy(busy1)
`ifdef MD5_CUSTOM_IV_EN
      , .iv_in(iv_in)
`endif
   );

   md5_stream_core #(.UNROLL(4)) dut4 (
      .clk(clk), .rst(rst), .s(if4), .busy(busy4)
`ifdef MD5_CUSTOM_IV_EN
      , .iv_in(iv_in)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int u, input bit v, input bit f, input bit l, input logic [511:0] d);
      if (u == 1) begin
         if1.in_valid = v; if1.in_first = f; if1.in_last = l; if1.in_data = d;
      end else begin
         if4.in_valid = v; if4.in_first = f; if4.in_last = l; if4.in_data = d;
      end
   endtask

   // Offers one block; acc returns the index of the accepting clock edge.
   task automatic send(input int u, input logic [511:0] d, input bit f, input bit l,
                       input bit push, input bit chk, input logic [127:0] exp, output int acc);
      exp_t e;
      acc = -1;
      @(negedge clk);
      drive(u, 1'b1, f, l, d);
      for (int i = 0; i < 300; i++) begin
         if ((u == 1) ? if1.in_ready : if4.in_ready) begin
            acc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      check("accept_in_time", 128'(acc >= 0), 128'(1));
      if (acc >= 0) begin
         if (push) begin
            e.hash = exp; e.acc = acc; e.chk = chk;
            if (u == 1) q1.push_back(e); else q4.push_back(e);
         end
         @(negedge clk);
      end
      drive(u, 1'b0, 1'b1, 1'b1, ~d);
   endtask

   task automatic drain(input int u);
      for (int i = 0; i < 400; i++) begin
         if (((u == 1) ? q1.size() : q4.size()) == 0) break;
         @(negedge clk);
      end
      check("scoreboard_drained", 128'((u == 1) ? q1.size() : q4.size()), 128'(0));
      repeat (2) @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (rst || !if1.hash_valid) seen1 = 0;
      else if (!seen1) begin
         seen1 = 1;
         if (q1.size() == 0) check("u1_spurious_hash_valid", 128'(1), 128'(0));
         else begin
            e1 = q1.pop_front();
            if (e1.chk) check("u1_hash", if1.hash, e1.hash);
            else begin cap_h = if1.hash; cap_done = 1; end
            check("u1_latency", 128'(cyc - e1.acc + 1), 128'(66));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst || !if4.hash_valid) seen4 = 0;
      else if (!seen4) begin
         seen4 = 1;
         if (q4.size() == 0) check("u4_spurious_hash_valid", 128'(1), 128'(0));
         else begin
            e4 = q4.pop_front();
            check("u4_hash", if4.hash, e4.hash);
            check("u4_latency", 128'(cyc - e4.acc + 1), 128'(18));
         end
      end
   end

   initial begin
      int a0, a1;
      rst = 1'b1;
      drive(1, 1'b0, 1'b0, 1'b0, '0);
      drive(4, 1'b0, 1'b0, 1'b0, '0);
      if1.hash_ready = 1'b1;
      if4.hash_ready = 1'b1;
`ifdef MD5_CUSTOM_IV_EN
      iv_in = IV_STD;
`endif
      repeat (3) @(negedge clk);
      check("rst_in_ready", 128'(if1.in_ready), 128'(0));
      check("rst_hash_valid", 128'(if1.hash_valid), 128'(0));
      check("rst_hash", if1.hash, 128'(0));
      check("rst_busy", 128'(busy1), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 128'(if1.in_ready), 128'(1));

      // Two-block message on the UNROLL=4 instance
      send(4, BLK_D1, 1'b1, 1'b0, 1'b0, 1'b1, '0, a0);
      send(4, BLK_D2, 1'b0, 1'b1, 1'b1, 1'b1, H_DIG, a1);
      check("u4_block_period", 128'(a1 - a0), 128'(18));
      drain(4);

      // Empty string, then "abc" back-to-back after a digest
      send(1, BLK_EMPTY, 1'b1, 1'b1, 1'b1, 1'b1, H_EMPTY, a0);
      send(1, BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b1, H_ABC, a1);
      check("u1_period_with_digest", 128'(a1 - a0), 128'(67));

      // Two-block message, no idle between blocks
      send(1, BLK_D1, 1'b1, 1'b0, 1'b0, 1'b1, '0, a0);
      check("u1_period_after_digest", 128'(a0 - a1), 128'(67));
      send(1, BLK_D2, 1'b0, 1'b1, 1'b1, 1'b1, H_DIG, a1);
      check("u1_period_no_digest", 128'(a1 - a0), 128'(66));
      drain(1);

      // Downstream stall in OUT
      if1.hash_ready = 1'b0;
      send(1, BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b1, H_ABC, a0);
      for (int i = 0; i < 200; i++) begin
         if (if1.hash_valid) break;
         @(negedge clk);
      end
      check("stall_reached_out", 128'(if1.hash_valid), 128'(1));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall_hash_valid", 128'(if1.hash_valid), 128'(1));
         check("stall_hash", if1.hash, H_ABC);
         check("stall_in_ready", 128'(if1.in_ready), 128'(0));
      end
      if1.hash_ready = 1'b1;
      @(negedge clk);
      if1.hash_ready = 1'b0;
      check("release_hash_valid", 128'(if1.hash_valid), 128'(0));
      check("release_in_ready", 128'(if1.in_ready), 128'(1));
      check("release_hash_holds", if1.hash, H_ABC);
      if1.hash_ready = 1'b1;
      drain(1);

      // Reset mid-RUN, then "abc" with in_first=0 chains from IV
      send(1, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b1, '0, a0);
      repeat (29) @(negedge clk);
      check("midrun_busy", 128'(busy1), 128'(1));
      rst = 1'b1;
      #1;
      check("abort_in_ready", 128'(if1.in_ready), 128'(0));
      check("abort_busy", 128'(busy1), 128'(0));
      check("abort_hash", if1.hash, 128'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_abort_in_ready", 128'(if1.in_ready), 128'(1));
      send(1, BLK_ABC, 1'b0, 1'b1, 1'b1, 1'b1, H_ABC, a0);
      drain(1);
      repeat (70) @(negedge clk);

`ifdef MD5_CUSTOM_IV_EN
      cap_done = 0;
      send(1, BLK_D1, 1'b1, 1'b1, 1'b1, 1'b0, '0, a0);
      drain(1);
      check("iv_captured", 128'(cap_done), 128'(1));
      iv_in = cap_h;
      send(1, BLK_D2, 1'b1, 1'b1, 1'b1, 1'b1, H_DIG, a0);
      drain(1);
      iv_in = IV_STD;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
